// File: rtl/adc_frame_capture.sv
// -----------------------------------------------------------------------------
// adc_frame_capture
//   Captures a frame of ADC samples into a circular buffer around a trigger
//   point. PRE_LEN samples before the trigger and DEPTH-PRE_LEN samples from the
//   trigger onward are kept. The frame is then read out oldest-first.
//
// Parameters
//   AW       : buffer address width, DEPTH = 2**AW samples
//   PRE_LEN  : pre-trigger sample count, 1..DEPTH-1
//
// Ports
//   CLK        in   single clock, posedge
//   RSTN       in   synchronous active-low reset
//   DIN        in   8-bit unsigned ADC sample, one per cycle
//   OTR_IN     in   ADC out-of-range flag aligned with DIN
//   ARM        in   capture start pulse (honoured only in IDLE)
//   TRIG_LEVEL in   trigger threshold
//   TRIG_EDGE  in   0 = rising, 1 = falling
//   FORCE_TRIG in   trigger immediately on the next accepted sample
//   DECIM      in   one sample accepted every DECIM+1 cycles
//   RD_REQ     in   readout request, one sample per asserted cycle
//   DOUT       out  read data, holds when DVALID is low
//   DVALID     out  DOUT valid, one cycle after RD_REQ
//   BUSY       out  capture in progress (FILL, WAIT_TRIG, POST)
//   DONE       out  frame ready for readout (READ)
//   OTR_SEEN   out  sticky out-of-range flag for the current frame
// -----------------------------------------------------------------------------
module adc_frame_capture #(
    parameter int AW      = 8,
    parameter int PRE_LEN = 64
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic [7:0] DIN,
    input  logic       OTR_IN,
    input  logic       ARM,
    input  logic [7:0] TRIG_LEVEL,
    input  logic       TRIG_EDGE,
    input  logic       FORCE_TRIG,
    input  logic [3:0] DECIM,
    input  logic       RD_REQ,
    output logic [7:0] DOUT,
    output logic       DVALID,
    output logic       BUSY,
    output logic       DONE,
    output logic       OTR_SEEN
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW-1:0] PRE_LAST  = AW'(PRE_LEN - 1);
    localparam logic [AW-1:0] POST_LAST = AW'(DEPTH - PRE_LEN - 1);
    localparam logic [AW-1:0] RD_LAST   = AW'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_WAIT_TRIG,
        S_POST,
        S_READ
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_smp_cnt;   // samples taken in FILL/POST, reads done in READ
    logic [3:0]    r_dec_cnt;
    logic [7:0]    r_prev;
    logic          r_prev_vld;
    logic          r_otr;
    logic [7:0]    r_dout;
    logic          r_dvalid;

    logic          w_capture;
    logic          w_accept;
    logic          w_level_trig;
    logic          w_trig;

    assign w_capture = (r_state == S_FILL) || (r_state == S_WAIT_TRIG) || (r_state == S_POST);
    assign w_accept  = w_capture && (r_dec_cnt == 4'd0);

    // Edge detection compares the current accepted sample against the
    // previous accepted one, so it is blind until one sample has been taken.
    always_comb begin
        w_level_trig = 1'b0;
        if (r_prev_vld) begin
            if (TRIG_EDGE)
                w_level_trig = (r_prev > TRIG_LEVEL) && (DIN <= TRIG_LEVEL);
            else
                w_level_trig = (r_prev < TRIG_LEVEL) && (DIN >= TRIG_LEVEL);
        end
    end

    assign w_trig = FORCE_TRIG || w_level_trig;

    // Next-state and status outputs
    always_comb begin
        w_next = r_state;
        BUSY   = 1'b0;
        DONE   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (ARM) w_next = S_FILL;
            end
            S_FILL: begin
                BUSY = 1'b1;
                if (w_accept && (r_smp_cnt == PRE_LAST)) w_next = S_WAIT_TRIG;
            end
            S_WAIT_TRIG: begin
                BUSY = 1'b1;
                // A one-sample post window is complete with the trigger itself.
                if (w_accept && w_trig) w_next = (POST_LAST == '0) ? S_READ : S_POST;
            end
            S_POST: begin
                BUSY = 1'b1;
                if (w_accept && (r_smp_cnt == POST_LAST)) w_next = S_READ;
            end
            S_READ: begin
                DONE = 1'b1;
                if (RD_REQ && (r_smp_cnt == RD_LAST)) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Sample buffer, no reset needed
    always_ff @(posedge CLK) begin
        if (RSTN && w_accept) r_mem[r_wr_ptr] <= DIN;
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_smp_cnt  <= '0;
            r_dec_cnt  <= '0;
            r_prev     <= '0;
            r_prev_vld <= 1'b0;
            r_otr      <= 1'b0;
            r_dout     <= '0;
            r_dvalid   <= 1'b0;
        end else begin
            r_dvalid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (ARM) begin
                        r_wr_ptr   <= '0;
                        r_smp_cnt  <= '0;
                        r_dec_cnt  <= '0;
                        r_prev_vld <= 1'b0;
                        r_otr      <= 1'b0;
                    end
                end
                S_FILL, S_WAIT_TRIG, S_POST: begin
                    // DECIM is sampled live; a shrinking DECIM wraps at once.
                    r_dec_cnt <= (r_dec_cnt >= DECIM) ? 4'd0 : r_dec_cnt + 4'd1;
                    if (w_accept) begin
                        r_wr_ptr   <= r_wr_ptr + PTR_ONE;
                        r_prev     <= DIN;
                        r_prev_vld <= 1'b1;
                        if (OTR_IN) r_otr <= 1'b1;
                        if (w_next == S_READ) begin
                            // Pointer after this write is the oldest sample.
                            r_smp_cnt <= '0;
                            r_rd_ptr  <= r_wr_ptr + PTR_ONE;
                        end else if (w_next == S_POST && r_state == S_WAIT_TRIG) begin
                            // Trigger sample counts as the first post sample.
                            r_smp_cnt <= PTR_ONE;
                        end else if (w_next == S_WAIT_TRIG && r_state == S_FILL) begin
                            r_smp_cnt <= '0;
                        end else if (r_state != S_WAIT_TRIG) begin
                            r_smp_cnt <= r_smp_cnt + PTR_ONE;
                        end
                    end
                end
                S_READ: begin
                    if (RD_REQ) begin
                        r_dout    <= r_mem[r_rd_ptr];
                        r_dvalid  <= 1'b1;
                        r_rd_ptr  <= r_rd_ptr + PTR_ONE;
                        r_smp_cnt <= r_smp_cnt + PTR_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign DOUT     = r_dout;
    assign DVALID   = r_dvalid;
    assign OTR_SEEN = r_otr;

endmodule

// File: tb/tb_adc_frame_capture.sv
// -----------------------------------------------------------------------------
// tb_adc_frame_capture
//   Directed self-checking bench for adc_frame_capture with AW=4, PRE_LEN=4.
//   A vector table covers the ramp/rising-trigger capture and readout; short
//   hand-written sequences cover forced trigger, decimation, OTR stickiness,
//   held RD_REQ and reset in the middle of capture and readout.
// -----------------------------------------------------------------------------
module tb_adc_frame_capture;

    logic       CLK = 1'b0;
    logic       RSTN = 1'b0;
    logic [7:0] DIN = '0;
    logic       OTR_IN = 1'b0;
    logic       ARM = 1'b0;
    logic [7:0] TRIG_LEVEL = '0;
    logic       TRIG_EDGE = 1'b0;
    logic       FORCE_TRIG = 1'b0;
    logic [3:0] DECIM = '0;
    logic       RD_REQ = 1'b0;
    logic [7:0] DOUT;
    logic       DVALID;
    logic       BUSY;
    logic       DONE;
    logic       OTR_SEEN;

    int checks = 0;
    int errors = 0;

    adc_frame_capture #(.AW(4), .PRE_LEN(4)) dut (
        .CLK        (CLK),
        .RSTN       (RSTN),
        .DIN        (DIN),
        .OTR_IN     (OTR_IN),
        .ARM        (ARM),
        .TRIG_LEVEL (TRIG_LEVEL),
        .TRIG_EDGE  (TRIG_EDGE),
        .FORCE_TRIG (FORCE_TRIG),
        .DECIM      (DECIM),
        .RD_REQ     (RD_REQ),
        .DOUT       (DOUT),
        .DVALID     (DVALID),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .OTR_SEEN   (OTR_SEEN)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       arm;
        logic [7:0] din;
        logic       rd;
        logic       e_busy;
        logic       e_done;
        logic       e_dval;
        logic [7:0] e_dout;
        logic       e_otr;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic arm, input logic [7:0] din, input logic rd,
                       input logic busy, input logic done, input logic dval,
                       input logic [7:0] dout, input logic otr);
        vec_t v;
        v.arm = arm; v.din = din; v.rd = rd;
        v.e_busy = busy; v.e_done = done; v.e_dval = dval;
        v.e_dout = dout; v.e_otr = otr;
        tbl.push_back(v);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".busy"},   32'(BUSY),     0);
        chk({tag, ".done"},   32'(DONE),     0);
        chk({tag, ".dvalid"}, 32'(DVALID),   0);
        chk({tag, ".dout"},   32'(DOUT),     0);
        chk({tag, ".otr"},    32'(OTR_SEEN), 0);
    endtask

    task automatic do_reset();
        RSTN = 1'b0;
        tick();
        tick();
        RSTN = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dv_cnt;
        int busy_cnt;

        // ---------------- reset state ----------------
        RSTN = 1'b0;
        #1;
        tick();
        tick();
        chk_all_zero("reset");
        RSTN = 1'b1;

        // ---------------- ramp, rising trigger at level 10 ----------------
        // Samples 0..21 are written; the last 16 (6..21) form the frame.
        // RD_REQ during capture and ARM in POST must have no effect.
        add(1, 8'd0, 0, 1, 0, 0, 8'd0, 0);
        for (int s = 0; s < 22; s++)
            add(s == 15, 8'(s), (s == 5) || (s == 17), s < 21, s == 21, 0, 8'd0, 0);
        for (int k = 0; k < 16; k++) begin
            add(0, 8'd0, 1, 0, k < 15, 1, 8'(6 + k), 0);
            if (k == 7) add(0, 8'd0, 0, 0, 1, 0, 8'd13, 0);
        end
        add(0, 8'd0, 1, 0, 0, 0, 8'd21, 0);

        TRIG_LEVEL = 8'd10;
        TRIG_EDGE  = 1'b0;
        DECIM      = 4'd0;
        foreach (tbl[i]) begin
            ARM    = tbl[i].arm;
            DIN    = tbl[i].din;
            RD_REQ = tbl[i].rd;
            tick();
            chk($sformatf("vec%0d.busy", i),   32'(BUSY),     32'(tbl[i].e_busy));
            chk($sformatf("vec%0d.done", i),   32'(DONE),     32'(tbl[i].e_done));
            chk($sformatf("vec%0d.dvalid", i), 32'(DVALID),   32'(tbl[i].e_dval));
            chk($sformatf("vec%0d.dout", i),   32'(DOUT),     32'(tbl[i].e_dout));
            chk($sformatf("vec%0d.otr", i),    32'(OTR_SEEN), 32'(tbl[i].e_otr));
        end
        ARM = 1'b0;
        RD_REQ = 1'b0;

        // ---------------- constant 50, falling at 50, forced trigger ----------------
        do_reset();
        DIN = 8'd50;
        TRIG_LEVEL = 8'd50;
        TRIG_EDGE = 1'b1;
        ARM = 1'b1;
        tick();
        ARM = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        chk("notrig.busy", 32'(BUSY), 1);
        chk("notrig.done", 32'(DONE), 0);
        FORCE_TRIG = 1'b1;
        tick();
        FORCE_TRIG = 1'b0;
        chk("force.otr_pre", 32'(OTR_SEEN), 0);
        for (int i = 0; i < 11; i++) begin
            OTR_IN = (i == 3);
            tick();
            if (i == 3) chk("otr.set", 32'(OTR_SEEN), 1);
            if (i == 9) chk("force.done_early", 32'(DONE), 0);
        end
        OTR_IN = 1'b0;
        chk("force.done", 32'(DONE), 1);
        chk("force.otr_read", 32'(OTR_SEEN), 1);
        // RD_REQ held 20 cycles: 16 pulses, then idle
        dv_cnt = 0;
        RD_REQ = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (DVALID) begin
                dv_cnt++;
                chk($sformatf("force.dout%0d", i), 32'(DOUT), 50);
            end
        end
        RD_REQ = 1'b0;
        chk("held.dvalid_count", 32'(dv_cnt), 16);
        chk("held.done", 32'(DONE), 0);
        chk("held.busy", 32'(BUSY), 0);
        chk("otr.hold_idle", 32'(OTR_SEEN), 1);
        ARM = 1'b1;
        tick();
        ARM = 1'b0;
        chk("otr.clear_arm", 32'(OTR_SEEN), 0);
        chk("rearm.busy", 32'(BUSY), 1);

        // ---------------- DECIM=2 ramp ----------------
        // Accepted values 0,3,6,...; rising at 30 triggers on 30 (j=10);
        // frame is j=6..21 -> 18..63; BUSY spans 64 cycles vs 22 at DECIM=0.
        do_reset();
        DECIM = 4'd2;
        TRIG_LEVEL = 8'd30;
        TRIG_EDGE = 1'b0;
        ARM = 1'b1;
        tick();
        ARM = 1'b0;
        busy_cnt = BUSY ? 1 : 0;
        for (int c = 0; c < 200; c++) begin
            DIN = 8'(c);
            tick();
            if (!BUSY) break;
            busy_cnt++;
        end
        chk("decim.busy_cycles", 32'(busy_cnt), 64);
        chk("decim.done", 32'(DONE), 1);
        RD_REQ = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            chk($sformatf("decim.dvalid%0d", k), 32'(DVALID), 1);
            chk($sformatf("decim.dout%0d", k), 32'(DOUT), 32'(18 + 3 * k));
        end
        RD_REQ = 1'b0;
        DECIM = 4'd0;

        // ---------------- reset mid-POST ----------------
        do_reset();
        DIN = 8'd77;
        TRIG_LEVEL = 8'd200;
        ARM = 1'b1;
        tick();
        ARM = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        FORCE_TRIG = 1'b1;
        tick();
        FORCE_TRIG = 1'b0;
        OTR_IN = 1'b1;
        tick();
        OTR_IN = 1'b0;
        tick();
        chk("post.busy_pre", 32'(BUSY), 1);
        chk("post.otr_pre", 32'(OTR_SEEN), 1);
        RSTN = 1'b0;
        tick();
        chk_all_zero("rst_post");
        RSTN = 1'b1;
        tick();
        chk("rst_post.idle_busy", 32'(BUSY), 0);

        // ---------------- reset mid-READ ----------------
        ARM = 1'b1;
        tick();
        ARM = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        FORCE_TRIG = 1'b1;
        tick();
        FORCE_TRIG = 1'b0;
        for (int i = 0; i < 11; i++) tick();
        chk("read.done_pre", 32'(DONE), 1);
        RD_REQ = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("read.dout_pre", 32'(DOUT), 77);
        chk("read.dvalid_pre", 32'(DVALID), 1);
        RSTN = 1'b0;
        tick();
        chk_all_zero("rst_read");
        RSTN = 1'b1;
        tick();
        chk("idle_rd.dvalid", 32'(DVALID), 0);
        chk("idle_rd.done", 32'(DONE), 0);
        RD_REQ = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
